my_top_level: RTL and testbench

//   Pipelined 8-bit unsigned adder: io_X = io_A + io_B, two clock cycles after sampling.
//   Top-level arithmetic block driven each cycle by a stimulus/BFM stage.

---
 rtl/my_top_level.sv | 50 +++++
 tb/tb_my_top_level.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/my_top_level.sv
// Two-stage pipelined unsigned adder with registered carry-out.
// Optional build macro MY_TOP_LEVEL_SATURATE_EN clamps io_X to all-ones on overflow.
module my_top_level #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_A,
    input  logic [WIDTH-1:0] io_B,
    output logic [WIDTH-1:0] io_X,
    output logic             io_carry
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             carry_q, carry_d;
    logic [WIDTH:0]   sum;

    always_comb begin
        a_d = io_A;
        b_d = io_B;
        sum = {1'b0, a_q} + {1'b0, b_q};
        carry_d = sum[WIDTH];
`ifdef MY_TOP_LEVEL_SATURATE_EN
        x_d = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
        x_d = sum[WIDTH-1:0];
`endif
    end

    // Asserting reset clears both stages at once, discarding any in-flight pair.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q     <= '0;
            b_q     <= '0;
            x_q     <= '0;
            carry_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            x_q     <= x_d;
            carry_q <= carry_d;
        end
    end

    assign io_X     = x_q;
    assign io_carry = carry_q;

endmodule

// File: tb/tb_my_top_level.sv
// Directed self-checking bench for my_top_level; expectations follow
// MY_TOP_LEVEL_SATURATE_EN when the bench is built with it defined.
module tb_my_top_level;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] ioA;
    logic [WIDTH-1:0] ioB;
    logic [WIDTH-1:0] ioX;
    logic             ioCarry;

    int checks = 0;
    int passed = 0;

    logic [1599:0] vec;
    logic [1599:0] shiftVec;
    logic [7:0]    pairA [0:101];
    logic [7:0]    pairB [0:101];
    logic [8:0]    expSum;

    my_top_level #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .io_A     (ioA),
        .io_B     (ioB),
        .io_X     (ioX),
        .io_carry (ioCarry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference sum: {carry, result} with optional saturation of the result.
    function automatic logic [8:0] modelSum(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef MY_TOP_LEVEL_SATURATE_EN
        if (s[8]) s[7:0] = 8'hFF;
`endif
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        ioA = a;
        ioB = b;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] expX, input logic expC);
        checks++;
        assert (ioX === expX) passed++;
        else begin
            $display("[TB] FAIL %s io_X: got %h, expected %h", tag, ioX, expX);
            $error("[TB] %s io_X check", tag);
        end
        checks++;
        assert (ioCarry === expC) passed++;
        else begin
            $display("[TB] FAIL %s io_carry: got %b, expected %b", tag, ioCarry, expC);
            $error("[TB] %s io_carry check", tag);
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(8'h55, 8'hAA);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("reset_initial", 8'h00, 1'b0);

        // Clocking while held in reset must leave everything cleared.
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("reset_held", 8'h00, 1'b0);
        end

        reset = 1'b1;
        applyStimulus(8'h12, 8'h34);
        tick();
        checkOutput("latency_one_edge", 8'h00, 1'b0);
        tick();
        checkOutput("add_12_34", 8'h46, 1'b0);

        applyStimulus(8'hFF, 8'h01);
        tick();
        tick();
`ifdef MY_TOP_LEVEL_SATURATE_EN
        checkOutput("ff_plus_01", 8'hFF, 1'b1);
`else
        checkOutput("ff_plus_01", 8'h00, 1'b1);
`endif

        for (int i = 0; i < 50; i++) vec[i*32 +: 32] = $urandom;
        vec[15:0]  = 16'h01FF;
        vec[31:16] = 16'hFFFF;
        vec[47:32] = 16'h0000;
        shiftVec = vec;
        for (int i = 0; i < 102; i++) begin
            if (i < 100) begin
                pairA[i] = shiftVec[7:0];
                pairB[i] = shiftVec[15:8];
                shiftVec = shiftVec >> 16;
            end else begin
                pairA[i] = 8'h00;
                pairB[i] = 8'h00;
            end
        end

        // Each edge's output reflects the pair driven one loop iteration earlier.
        for (int i = 0; i < 102; i++) begin
            applyStimulus(pairA[i], pairB[i]);
            tick();
            if (i >= 1) begin
                expSum = modelSum(pairA[i-1], pairB[i-1]);
                checkOutput($sformatf("stream_%0d", i-1), expSum[7:0], expSum[8]);
            end
        end
        tick();
        checkOutput("stream_settle", 8'h00, 1'b0);

        applyStimulus(8'h80, 8'h80);
        tick();
        tick();
        tick();
`ifdef MY_TOP_LEVEL_SATURATE_EN
        checkOutput("add_80_80", 8'hFF, 1'b1);
`else
        checkOutput("add_80_80", 8'h00, 1'b1);
`endif
        applyStimulus(8'h01, 8'h02);
        tick();
        checkOutput("pre_reset_80_80_flush", (modelSum(8'h80, 8'h80) & 9'h0FF), 1'b1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_immediate", 8'h00, 1'b0);
        tick();
        checkOutput("async_reset_hold", 8'h00, 1'b0);
        reset = 1'b1;
        applyStimulus(8'h80, 8'h80);
        tick();
        checkOutput("post_release_one_edge", 8'h00, 1'b0);
        tick();
`ifdef MY_TOP_LEVEL_SATURATE_EN
        checkOutput("post_release_80_80", 8'hFF, 1'b1);
`else
        checkOutput("post_release_80_80", 8'h00, 1'b1);
`endif

        applyStimulus(8'hFF, 8'hFF);
        tick();
        tick();
`ifdef MY_TOP_LEVEL_SATURATE_EN
        checkOutput("ff_plus_ff", 8'hFF, 1'b1);
`else
        checkOutput("ff_plus_ff", 8'hFE, 1'b1);
`endif
        tick();
`ifdef MY_TOP_LEVEL_SATURATE_EN
        checkOutput("ff_plus_ff_hold", 8'hFF, 1'b1);
`else
        checkOutput("ff_plus_ff_hold", 8'hFE, 1'b1);
`endif

        applyStimulus(8'h00, 8'h00);
        tick();
        tick();
        checkOutput("zero_plus_zero", 8'h00, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
